// File: rtl/servant_sleep_ctrl.sv
// Sleep/wake sequencer for the servant core.
// Takes the core's sleep request, waits for the Wishbone bus to go idle, and
// then drops a registered enable for an external glitch-free clock gate.
// A synchronised external IRQ edge or a timer IRQ level restores the clock,
// and the core gets a one-cycle wake pulse.
// Runs entirely on the ungated i_clk.
module servant_sleep_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WAKE_CYCLES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sleep_req,
  input  logic        i_wb_cyc,
  input  logic        i_ext_irq,
  input  logic        i_timer_irq,
  output logic        o_clk_en,
  output logic        o_wakeup_req,
  output logic        o_sleeping,
  output logic [15:0] o_wake_count
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StSleep = 2'd2;
  localparam logic [1:0] StWake  = 2'd3;

  localparam logic [7:0] DrainLoad = 8'(DRAIN_CYCLES);
  // The WAKE state leaves on the edge where the counter is already zero.
  localparam logic [7:0] WakeLoad  = 8'(WAKE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        clk_en_q, clk_en_d;
  logic        wakeup_q, wakeup_d;
  logic        sleeping_q, sleeping_d;
  logic [15:0] wake_count_q, wake_count_d;
  logic        s1_q, s2_q, s3_q;
  logic        sleep_prev_q;

  logic ext_rise;
  logic wake_evt;
  logic sleep_rise;

  assign ext_rise   = s2_q & ~s3_q;
  assign wake_evt   = ext_rise | i_timer_irq;
  assign sleep_rise = i_sleep_req & ~sleep_prev_q;

  // Next-state logic for the sleep/wake sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_en_d     = clk_en_q;
    sleeping_d   = sleeping_q;
    wakeup_d     = 1'b0;
    wake_count_d = wake_count_q;
    case (state_q)
      StRun: begin
        clk_en_d   = 1'b1;
        sleeping_d = 1'b0;
        if (sleep_rise) begin
          if (wake_evt) begin
            // Immediate refusal: tell the core to carry on.
            wakeup_d = 1'b1;
          end else begin
            state_d = StDrain;
            cnt_d   = DrainLoad;
          end
        end
      end
      StDrain: begin
        if (wake_evt) begin
          state_d  = StRun;
          wakeup_d = 1'b1;
        end else if (i_wb_cyc) begin
          // Idle cycles must be consecutive.
          cnt_d = DrainLoad;
        end else if (cnt_q == 8'd0) begin
          state_d    = StSleep;
          clk_en_d   = 1'b0;
          sleeping_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSleep: begin
        if (wake_evt) begin
          state_d    = StWake;
          clk_en_d   = 1'b1;
          sleeping_d = 1'b0;
          cnt_d      = WakeLoad;
        end
      end
      StWake: begin
        if (cnt_q == 8'd0) begin
          state_d      = StRun;
          wakeup_d     = 1'b1;
          wake_count_d = wake_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d    = StRun;
        clk_en_d   = 1'b1;
        sleeping_d = 1'b0;
      end
    endcase
  end

  // State, outputs, IRQ synchroniser and sleep edge register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StRun;
      cnt_q        <= 8'd0;
      clk_en_q     <= 1'b1;
      wakeup_q     <= 1'b0;
      sleeping_q   <= 1'b0;
      wake_count_q <= 16'd0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      sleep_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_en_q     <= clk_en_d;
      wakeup_q     <= wakeup_d;
      sleeping_q   <= sleeping_d;
      wake_count_q <= wake_count_d;
      s1_q         <= i_ext_irq;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      sleep_prev_q <= i_sleep_req;
    end
  end

  assign o_clk_en     = clk_en_q;
  assign o_wakeup_req = wakeup_q;
  assign o_sleeping   = sleeping_q;
  assign o_wake_count = wake_count_q;

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// Directed bench for servant_sleep_ctrl (DRAIN_CYCLES=2, WAKE_CYCLES=2).
// Expected outputs are queued when stimulus is applied and popped for
// comparison once the DUT has had the stated number of edges.
module tb_servant_sleep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sleep_req;
  logic        wb_cyc;
  logic        ext_irq;
  logic        timer_irq;
  logic        clk_en;
  logic        wakeup_req;
  logic        sleeping;
  logic [15:0] wake_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic        ce;
    logic        sl;
    logic        wk;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  servant_sleep_ctrl #(
    .DRAIN_CYCLES(2),
    .WAKE_CYCLES (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sleep_req (sleep_req),
    .i_wb_cyc    (wb_cyc),
    .i_ext_irq   (ext_irq),
    .i_timer_irq (timer_irq),
    .o_clk_en    (clk_en),
    .o_wakeup_req(wakeup_req),
    .o_sleeping  (sleeping),
    .o_wake_count(wake_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the expected outputs, run n edges, then pop and compare.
  task automatic expect_after(input int n, input string tag, input logic ce, input logic sl,
                              input logic wk, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.ce = ce; e.sl = sl; e.wk = wk; e.cnt = cnt;
    sb.push_back(e);
    tick(n);
    e = sb.pop_front();
    tests++;
    assert (clk_en === e.ce) else begin
      fails++;
      $error("FAIL %s clk_en obs=%b exp=%b", e.tag, clk_en, e.ce);
    end
    tests++;
    assert (sleeping === e.sl) else begin
      fails++;
      $error("FAIL %s sleeping obs=%b exp=%b", e.tag, sleeping, e.sl);
    end
    tests++;
    assert (wakeup_req === e.wk) else begin
      fails++;
      $error("FAIL %s wakeup_req obs=%b exp=%b", e.tag, wakeup_req, e.wk);
    end
    tests++;
    assert (wake_count === e.cnt) else begin
      fails++;
      $error("FAIL %s wake_count obs=%0h exp=%0h", e.tag, wake_count, e.cnt);
    end
  endtask

  // One-cycle timer pulse from SLEEP; the wake pulse lands two edges later.
  task automatic timer_wake(input string tag, input logic [15:0] cnt);
    timer_irq = 1'b1;
    expect_after(1, {tag, "_ce"}, 1'b1, 1'b0, 1'b0, cnt - 16'd1);
    timer_irq = 1'b0;
    tick(1);
    expect_after(1, tag, 1'b1, 1'b0, 1'b1, cnt);
    expect_after(1, {tag, "_end"}, 1'b1, 1'b0, 1'b0, cnt);
  endtask

  initial begin
    rst       = 1'b1;
    sleep_req = 1'b0;
    wb_cyc    = 1'b0;
    ext_irq   = 1'b0;
    timer_irq = 1'b0;
    expect_after(2, "reset", 1'b1, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    tick(1);

    // Basic cycle: sleep after 4 edges, timer wake.
    sleep_req = 1'b1;
    expect_after(3, "drain", 1'b1, 1'b0, 1'b0, 16'd0);
    expect_after(1, "sleep", 1'b0, 1'b1, 1'b0, 16'd0);
    timer_wake("basic_wake", 16'd1);
    // Request still held: no re-trigger without a new rising edge.
    expect_after(3, "held_req", 1'b1, 1'b0, 1'b0, 16'd1);
    sleep_req = 1'b0;
    tick(1);

    // Bus busy for 10 cycles, then 3 idle edges to gate.
    wb_cyc    = 1'b1;
    sleep_req = 1'b1;
    for (int i = 0; i < 10; i++) expect_after(1, "busy", 1'b1, 1'b0, 1'b0, 16'd1);
    wb_cyc = 1'b0;
    expect_after(2, "busy_idle2", 1'b1, 1'b0, 1'b0, 16'd1);
    expect_after(1, "busy_sleep", 1'b0, 1'b1, 1'b0, 16'd1);
    timer_wake("busy_wake", 16'd2);
    sleep_req = 1'b0;
    tick(1);

    // Bus blip mid-drain reloads the counter.
    sleep_req = 1'b1;
    tick(2);
    wb_cyc = 1'b1;
    tick(1);
    wb_cyc = 1'b0;
    expect_after(2, "reload", 1'b1, 1'b0, 1'b0, 16'd2);
    expect_after(1, "reload_sleep", 1'b0, 1'b1, 1'b0, 16'd2);
    timer_wake("reload_wake", 16'd3);
    sleep_req = 1'b0;
    tick(1);

    // External IRQ raised asynchronously in SLEEP.
    sleep_req = 1'b1;
    expect_after(4, "ext_sleep", 1'b0, 1'b1, 1'b0, 16'd3);
    #3 ext_irq = 1'b1;
    expect_after(2, "ext_sync", 1'b0, 1'b1, 1'b0, 16'd3);
    expect_after(1, "ext_wake", 1'b1, 1'b0, 1'b0, 16'd3);
    expect_after(1, "ext_mid", 1'b1, 1'b0, 1'b0, 16'd3);
    expect_after(1, "ext_pulse", 1'b1, 1'b0, 1'b1, 16'd4);
    sleep_req = 1'b0;
    tick(1);
    // Held IRQ level must not wake a fresh sleep.
    sleep_req = 1'b1;
    expect_after(4, "hold_sleep", 1'b0, 1'b1, 1'b0, 16'd4);
    expect_after(6, "hold_nowake", 1'b0, 1'b1, 1'b0, 16'd4);
    ext_irq = 1'b0;
    tick(3);
    ext_irq = 1'b1;
    expect_after(3, "ext_rewake", 1'b1, 1'b0, 1'b0, 16'd4);
    expect_after(2, "ext_repulse", 1'b1, 1'b0, 1'b1, 16'd5);
    ext_irq   = 1'b0;
    sleep_req = 1'b0;
    tick(3);

    // Timer IRQ during DRAIN aborts; count unchanged.
    sleep_req = 1'b1;
    expect_after(2, "abort_drain", 1'b1, 1'b0, 1'b0, 16'd5);
    timer_irq = 1'b1;
    expect_after(1, "abort", 1'b1, 1'b0, 1'b1, 16'd5);
    timer_irq = 1'b0;
    expect_after(1, "abort_end", 1'b1, 1'b0, 1'b0, 16'd5);
    expect_after(3, "abort_run", 1'b1, 1'b0, 1'b0, 16'd5);
    sleep_req = 1'b0;
    tick(1);

    // Sleep edge coincident with timer IRQ is refused.
    timer_irq = 1'b1;
    sleep_req = 1'b1;
    expect_after(1, "refuse", 1'b1, 1'b0, 1'b1, 16'd5);
    timer_irq = 1'b0;
    expect_after(4, "refuse_run", 1'b1, 1'b0, 1'b0, 16'd5);
    sleep_req = 1'b0;
    tick(1);

    // Wake counter wraps from 0xFFFF.
    force dut.wake_count_q = 16'hFFFF;
    tick(1);
    release dut.wake_count_q;
    expect_after(1, "preload", 1'b1, 1'b0, 1'b0, 16'hFFFF);
    sleep_req = 1'b1;
    expect_after(4, "wrap_sleep", 1'b0, 1'b1, 1'b0, 16'hFFFF);
    timer_wake("wrap", 16'h0000);
    sleep_req = 1'b0;
    tick(1);

    // Reset in SLEEP restores the clock on the next edge.
    sleep_req = 1'b1;
    expect_after(4, "rst_sleep", 1'b0, 1'b1, 1'b0, 16'h0000);
    rst = 1'b1;
    expect_after(1, "rst_in_sleep", 1'b1, 1'b0, 1'b0, 16'h0000);
    rst       = 1'b0;
    sleep_req = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
